// File: rtl/mul_seq_ctrl.sv
// MulSeqCtrl: sequencing stage around the 4x4 shift-add multiplier.
// Accepts an operand pair, pulses clear then start to the multiplier,
// waits out its fixed latency, captures the product and holds it until
// the consumer takes it.
module mul_seq_ctrl #(
    parameter int MUL_LAT = 10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_multiplicand,
    input  logic [3:0] in_multiplier,
    output logic       mul_clear,
    output logic       mul_ready,
    output logic [3:0] mul_multiplicand,
    output logic [3:0] mul_multiplier,
    input  logic [7:0] mul_product,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_product,
    output logic [7:0] op_count
);

    // The counter is loaded with MUL_LAT-1 so that the capture happens in the
    // cycle where the multiplier output has just become stable.
    localparam logic [4:0] LP_WAIT_LOAD = 5'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [4:0] r_waitCnt;
    logic [3:0] r_opA;
    logic [3:0] r_opB;
    logic [7:0] r_product;
    logic [7:0] r_opCount;

    // State register; clear forces IDLE from any state.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: one pass IDLE -> CLR -> START -> WAIT -> HOLD -> IDLE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_stateNext = S_CLR;
            S_CLR:   w_stateNext = S_START;
            S_START: w_stateNext = S_WAIT;
            S_WAIT:  if (r_waitCnt == 5'd0) w_stateNext = S_HOLD;
            S_HOLD:  if (out_ready) w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Moore outputs decoded purely from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        mul_clear = 1'b0;
        mul_ready = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_CLR:   mul_clear = 1'b1;
            S_START: mul_ready = 1'b1;
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch, latency counter, product capture, transfer count.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_opA     <= 4'd0;
            r_opB     <= 4'd0;
            r_waitCnt <= 5'd0;
            r_product <= 8'd0;
            r_opCount <= 8'd0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_opA <= in_multiplicand;
                r_opB <= in_multiplier;
            end
            if (r_state == S_START) begin
                r_waitCnt <= LP_WAIT_LOAD;
            end else if (r_state == S_WAIT && r_waitCnt != 5'd0) begin
                r_waitCnt <= r_waitCnt - 5'd1;
            end
            if (r_state == S_WAIT && r_waitCnt == 5'd0) begin
                r_product <= mul_product;
            end
            if (r_state == S_HOLD && out_ready) begin
                r_opCount <= r_opCount + 8'd1;
            end
        end
    end

    assign mul_multiplicand = r_opA;
    assign mul_multiplier   = r_opB;
    assign out_product      = r_product;
    assign op_count         = r_opCount;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a stub multiplier whose product
// only becomes valid MUL_LAT cycles after the start pulse.
module tb_mul_seq_ctrl;

    localparam int MUL_LAT = 10;

    logic       clk = 1'b0;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_multiplicand;
    logic [3:0] in_multiplier;
    logic       mul_clear;
    logic       mul_ready;
    logic [3:0] mul_multiplicand;
    logic [3:0] mul_multiplier;
    logic [7:0] mul_product;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    logic [7:0] expQ[$];
    int         hsQ[$];
    int         hsLast = -1;
    int         expCount = 0;
    bit         spacingCheck = 1'b0;
    bit         prevValid = 1'b0;
    bit         prevXfer = 1'b0;
    logic [7:0] prevProduct = 8'd0;

    logic [3:0] stubA = 4'd0;
    logic [3:0] stubB = 4'd0;
    int         stubCnt = 0;

    mul_seq_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk              (clk),
        .clear            (clear),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .mul_clear        (mul_clear),
        .mul_ready        (mul_ready),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .op_count         (op_count)
    );

    // Free-running clock and edge counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Stub multiplier: garbage until MUL_LAT cycles after the start pulse.
    always @(posedge clk) begin
        if (clear || mul_clear) begin
            stubCnt <= 0;
        end else if (mul_ready) begin
            stubA   <= mul_multiplicand;
            stubB   <= mul_multiplier;
            stubCnt <= 1;
        end else if (stubCnt > 0 && stubCnt < 1000) begin
            stubCnt <= stubCnt + 1;
        end
    end

    assign mul_product = (stubCnt >= MUL_LAT) ? ({4'd0, stubA} * {4'd0, stubB}) : 8'hEE;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pulse timing, latency, hold stability and scoreboard pops.
    always @(negedge clk) begin
        if (clear) begin
            expQ.delete();
            hsQ.delete();
            hsLast    = -1;
            expCount  = 0;
            prevValid = 1'b0;
            prevXfer  = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (spacingCheck && hsLast >= 0)
                    checkOutput("hs_spacing", cycleCnt - hsLast, MUL_LAT + 4);
                hsLast = cycleCnt;
                hsQ.push_back(cycleCnt);
            end
            if (mul_clear) checkOutput("clr_timing", cycleCnt - hsLast, 1);
            if (mul_ready) checkOutput("start_timing", cycleCnt - hsLast, 2);
            if (out_valid) begin
                if (!prevValid) begin
                    if (hsQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_valid: got out_valid=1, expected no pending op");
                    end else begin
                        checkOutput("latency", cycleCnt - hsQ.pop_front(), MUL_LAT + 3);
                    end
                end else if (!prevXfer) begin
                    checkOutput("hold_stable", out_product, prevProduct);
                end
                checkOutput("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL extra_xfer: got product %0d, expected none", out_product);
                    end else begin
                        checkOutput("product", out_product, expQ.pop_front());
                    end
                    checkOutput("op_count_pre", op_count, expCount);
                    expCount = (expCount + 1) % 256;
                end
            end
            prevValid   = out_valid;
            prevProduct = out_product;
            prevXfer    = out_valid && out_ready;
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_mul_clear", mul_clear, 0);
        checkOutput("rst_mul_ready", mul_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_product", out_product, 0);
        checkOutput("rst_mcand", mul_multiplicand, 0);
        checkOutput("rst_mplier", mul_multiplier, 0);
        checkOutput("rst_op_count", op_count, 0);
    endtask

    // Present one operand pair, queue its expected product, wait for acceptance.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] expProduct, input bit keepValid);
        bit done = 1'b0;
        in_multiplicand = a;
        in_multiplier   = b;
        in_valid        = 1'b1;
        expQ.push_back(expProduct);
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++;
            $display("[TB] FAIL handshake_timeout: got in_ready=0, expected 1");
        end
        if (!keepValid) in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
        end
    endtask

    initial begin
        clear           = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = 4'd0;
        in_multiplier   = 4'd0;
        out_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doClear();
        checkResetValues();

        // Clear during the fifth WAIT cycle discards the operation.
        out_ready = 1'b1;
        applyStimulus(4'd6, 4'd11, 8'd66, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midwait_mcand", mul_multiplicand, 6);
        doClear();
        checkResetValues();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midwait_count", op_count, 0);

        // Single operation and operand extremes.
        applyStimulus(4'd7, 4'd9, 8'd63, 1'b0);
        waitDrain();
        checkOutput("single_count", op_count, 1);
        applyStimulus(4'd15, 4'd15, 8'd225, 1'b0);
        waitDrain();
        applyStimulus(4'd0, 4'd13, 8'd0, 1'b0);
        waitDrain();
        checkOutput("max_count", op_count, 3);

        // Backpressure in HOLD for 20 cycles.
        out_ready = 1'b0;
        applyStimulus(4'd10, 4'd12, 8'd120, 1'b0);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        #1;
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_product", out_product, 120);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle", in_ready, 1);
        checkOutput("bp_count", op_count, 4);

        // New operands offered mid-operation are ignored.
        applyStimulus(4'd3, 4'd5, 8'd15, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        in_valid        = 1'b1;
        in_multiplicand = 4'd12;
        in_multiplier   = 4'd14;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ign_mcand", mul_multiplicand, 3);
        checkOutput("ign_mplier", mul_multiplier, 5);
        in_valid = 1'b0;
        waitDrain();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ign_count", op_count, 5);

        // 256 back-to-back operations: spacing and counter wrap.
        doClear();
        spacingCheck = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            applyStimulus(v[3:0], v[7:4], {4'd0, v[3:0]} * {4'd0, v[7:4]}, 1'b1);
        end
        in_valid = 1'b0;
        waitDrain();
        spacingCheck = 1'b0;
        checkOutput("wrap_count", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Function summary: sequencing stage in front of and behind the 4x4 shift-add multiplier. It accepts operand pairs, clears and starts the multiplier, waits its fixed latency, then captures the 8-bit product and holds it for the consumer.

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 10, meaning the number of clk cycles from the mul_ready pulse to a stable mul_product (range 2..31).
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 Port clear SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port in_valid SHALL be an input, 1 bit: the upstream operand pair is valid.
REQ-005 Port in_ready SHALL be an output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 Port in_multiplicand SHALL be an input, 4 bits: the operand A.
REQ-007 Port in_multiplier SHALL be an input, 4 bits: the operand B.
REQ-008 Port mul_clear SHALL be an output, 1 bit: the clear pulse to the multiplier.
REQ-009 Port mul_ready SHALL be an output, 1 bit: the start pulse to the multiplier.
REQ-010 Port mul_multiplicand SHALL be an output, 4 bits: the registered operand A to the multiplier.
REQ-011 Port mul_multiplier SHALL be an output, 4 bits: the registered operand B to the multiplier.
REQ-012 Port mul_product SHALL be an input, 8 bits: the multiplier result.
REQ-013 Port out_valid SHALL be an output, 1 bit: the product is held and valid.
REQ-014 Port out_ready SHALL be an input, 1 bit: the downstream consumer accepts the product.
REQ-015 Port out_product SHALL be an output, 8 bits: the captured product.
REQ-016 Port op_count SHALL be an output, 8 bits: the number of completed transfers, wrapping modulo 256.

Function
REQ-017 The FSM SHALL have the states IDLE, CLR, START, WAIT and HOLD, all registered.
REQ-018 In IDLE, in_ready SHALL be 1; when in_valid=1, the block SHALL latch both operands into mul_multiplicand and mul_multiplier and go to CLR.
REQ-019 In CLR, mul_clear SHALL be 1 for exactly one cycle; the next state SHALL be START.
REQ-020 In START, mul_ready SHALL be 1 for exactly one cycle; the wait counter SHALL be loaded with MUL_LAT-1; the next state SHALL be WAIT.
REQ-021 In WAIT, the wait counter SHALL decrement by one each cycle; when it equals 0, out_product SHALL capture mul_product and the next state SHALL be HOLD.
REQ-022 In HOLD, out_valid SHALL be 1; out_product and out_valid SHALL remain stable until out_ready=1.
REQ-023 On a HOLD cycle with out_ready=1, op_count SHALL increment by 1 (255 wraps to 0) and the next state SHALL be IDLE.
REQ-024 in_ready SHALL be 0 in every state other than IDLE; no operand is accepted mid-operation.
REQ-025 mul_multiplicand and mul_multiplier SHALL remain constant from CLR through HOLD.
REQ-026 Latency from the in_valid/in_ready handshake to out_valid=1 SHALL be MUL_LAT+3 cycles.
REQ-027 Back-to-back operation: after the HOLD exit, IDLE SHALL accept a new pair on the very next cycle; throughput SHALL be 1 product per MUL_LAT+4 cycles at best.
REQ-028 out_ready=1 outside HOLD SHALL be ignored; in_valid=0 in IDLE SHALL keep the block in IDLE.
REQ-029 Product width: out_product SHALL be the full 8 bits of mul_product, unmodified.

Reset
REQ-030 With clear=1 at a clock edge, the state SHALL go to IDLE and the wait counter SHALL be 0.
REQ-031 Output values on that clear edge SHALL be: in_ready=1, mul_clear=0, mul_ready=0, out_valid=0, out_product=0, mul_multiplicand=0, mul_multiplier=0, op_count=0.
REQ-032 clear SHALL take priority over all other inputs in every state, including mid-WAIT and mid-HOLD; any in-flight product is discarded and op_count is not incremented.

Verification
REQ-033 Scenario single op: MUL_LAT=10, A=4'd7, B=4'd9, out_ready=1, stub multiplier -> mul_clear 1 cycle, then mul_ready 1 cycle, out_valid 13 cycles after the handshake, out_product=8'd63, op_count=1.
REQ-034 Scenario max operands: A=4'd15, B=4'd15 -> out_product=8'd225; A=0, B=4'd13 -> out_product=0.
REQ-035 Scenario backpressure: out_ready=0 for 20 cycles in HOLD -> out_valid stays 1, out_product stable, in_ready=0; out_ready=1 -> IDLE next cycle, op_count+1.
REQ-036 Scenario reset mid-WAIT: clear=1 on WAIT cycle 5 -> next cycle IDLE, all outputs at reset values, op_count unchanged at 0.
REQ-037 Scenario wrap and throughput: 256 back-to-back ops with in_valid and out_ready held at 1 -> op_count wraps to 0, ops spaced exactly MUL_LAT+4 cycles apart.
REQ-038 Scenario ignored input: in_valid toggled during WAIT with new operands -> mul_multiplicand and mul_multiplier unchanged, no extra transfer.
